dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory load/store traffic. Supports wait states.
- Accepts one load or store request over a valid/ready handshake.
- Performs the byte, half or word access against internal word storage.
- Returns read data or an error flag over a second valid/ready handshake.
- Sits on the far side of the core's load/store path, replacing the zero-latency data_mem when multi-cycle memory timing is exercised.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit storage words; word index is req_addr[31:2].
- WAIT_CYCLES, 2, extra wait cycles between request acceptance and the commit edge (0 allowed).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous reset, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wr  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width code: 0 B, 1 H, 2 W, 4 BU, 5 HU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; low byte or half is used for SB/SH.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  32  load result after extension; 0 for stores and errors.
- rsp_err  output  1  misaligned, illegal funct3 or out-of-range access.

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (rst low, asynchronous):
  - state goes to IDLE; wait counter 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; latched request fields cleared.
  - Storage contents are not reset.
  - Requests are ignored while rst is low.
- req_ready = 1 exactly when state is IDLE (combinational from state).
- IDLE:
  - On req_valid and req_ready at an edge, latch req_wr, req_funct3, req_addr and req_wdata.
  - Load counter with WAIT_CYCLES and go to WAIT.
  - Input changes after acceptance have no effect.
- WAIT:
  - Each edge with counter > 0 decrements the counter.
  - The edge with counter == 0 is the commit edge: perform the access, register rsp_rdata and rsp_err, set rsp_valid = 1, go to RESP.
  - Latency: request accepted at edge N, so rsp_valid is high from edge N+1+WAIT_CYCLES.
- Error conditions, checked on the latched request:
  - H/HU/SH with addr[0] != 0.
  - W/SW with addr[1:0] != 0.
  - Load funct3 in {3, 6, 7}.
  - Store funct3 not in {0, 1, 2}.
  - Word index >= DEPTH_WORDS.
  - On error: no storage write, rsp_rdata = 0, rsp_err = 1.
- Store:
  - Little-endian byte lanes.
  - SB writes lane addr[1:0]; SH writes lanes addr[1]*2 and addr[1]*2+1; SW writes all 4 lanes. Other lanes are unchanged.
  - rsp_rdata = 0.
- Load:
  - Selects the byte or half by addr[1:0]. B and H sign-extend; BU and HU zero-extend; W returns the word unchanged.
  - Loading a word written by an earlier completed store returns that store's data.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable while rsp_ready = 0.
  - On the edge with rsp_ready = 1: rsp_valid = 0, go to IDLE; rsp_rdata and rsp_err keep their values until the next commit.
  - A new request can be accepted no earlier than the edge after the response handshake, because req_ready = 0 in RESP.
  - Maximum one outstanding request.
- Reset mid-operation:
  - Reset in WAIT before the commit edge means no storage write occurs.
  - Reset in RESP drops the response (rsp_valid = 0); a write already committed remains in storage.
- Counter width is sized to hold WAIT_CYCLES. WAIT_CYCLES = 0 gives the commit on the edge after acceptance.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10, WAIT_CYCLES = 2 -> each rsp_valid rises 3 edges after acceptance; LW rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- After the above, LB 0x13 -> rsp_rdata 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 wdata 0x00000055, then LW 0x10 -> 0xDEAD55EF; SH 0x12 wdata 0x1234, then LW 0x10 -> 0x123455EF.
- LW 0x12, SH 0x21, load funct3 = 3, SW 0x400 (DEPTH 256) -> rsp_err = 1 and rsp_rdata = 0 on each; a following LW 0x10 still returns 0x123455EF.
- Hold rsp_ready = 0 for 5 cycles during a response -> rsp_valid, rsp_rdata and rsp_err stay constant and req_ready = 0 throughout; rsp_ready = 1 gives IDLE on the next edge.
- Accept SW 0x20 wdata 0xAAAAAAAA; drive rst low during WAIT for 1 cycle -> rsp_valid = 0 and req_ready = 1. Then SW 0x20 wdata 0x0 followed by LW 0x20 -> 0x00000000, and the aborted write never appears.

Source files
------------

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response handshakes between a core and its data memory.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (
        output req_valid, req_wr, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_wr, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated data memory answering one byte/half/word load or store at a time.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);
    localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           wr_q, wr_d, valid_q, valid_d, err_q, err_d;
    logic [2:0]     f3_q, f3_d;
    logic [31:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [31:0]    mem [DEPTH_WORDS];
    logic [IW-1:0]  idx;
    logic [31:0]    word, ld, be_bits, st_data, merged;
    logic [15:0]    lane;
    logic           err, commit;
    always_comb begin
        idx     = addr_q[IW+1:2];
        word    = mem[idx];
        lane    = 16'(word >> {addr_q[1:0], 3'b000});
        ld      = f3_q == 3'd0 ? {{24{lane[7]}}, lane[7:0]} :
                  f3_q == 3'd4 ? {24'b0, lane[7:0]} :
                  f3_q == 3'd1 ? {{16{lane[15]}}, lane} :
                  f3_q == 3'd5 ? {16'b0, lane} : word;
        be_bits = f3_q[1:0] == 2'd0 ? 32'h0000_00ff << {addr_q[1:0], 3'b000} :
                  f3_q[1:0] == 2'd1 ? 32'h0000_ffff << {addr_q[1], 4'b0000} : 32'hffff_ffff;
        st_data = f3_q[1:0] == 2'd0 ? {4{wdata_q[7:0]}} :
                  f3_q[1:0] == 2'd1 ? {2{wdata_q[15:0]}} : wdata_q;
        merged  = (word & ~be_bits) | (st_data & be_bits);
        err     = (wr_q ? f3_q > 3'd2 : (f3_q == 3'd3 || f3_q[2:1] == 2'b11)) ||
                  (f3_q[1:0] == 2'd1 && addr_q[0]) ||
                  (f3_q[1:0] == 2'd2 && addr_q[1:0] != 2'd0) ||
                  ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
        commit  = state_q == WAIT && cnt_q == '0;
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                wr_d    = bus.req_wr;
                f3_d    = bus.req_funct3;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                cnt_d   = CW'(WAIT_CYCLES);
                state_d = WAIT;
            end
            WAIT: if (commit) begin
                valid_d = 1'b1;
                rdata_d = (err || wr_q) ? 32'h0 : ld;
                err_d   = err;
                state_d = RESP;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            RESP: if (bus.rsp_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end
    // storage is deliberately unreset; the rst gate blocks a commit racing a reset
    always_ff @(posedge clk) begin
        if (rst && commit && wr_q && !err) mem[idx] <= merged;
    end
    assign bus.req_ready = state_q == IDLE;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random load/store traffic checked against a byte-array memory model.
module tb_dmem_responder;
    localparam int W = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mdl [1024];
    dmem_if bus();
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_op(input logic wr, input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int sz;
        sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        er = (wr ? f > 3'd2 : (f == 3'd3 || f >= 3'd6)) || (a % sz != 0) || (a / 4 >= 256);
        rd = 32'h0;
        if (!er) begin
            if (wr) begin
                for (int i = 0; i < sz; i++) mdl[a[9:0] + 10'(i)] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < sz; i++) rd = rd | (32'(mdl[a[9:0] + 10'(i)]) << (8*i));
                if (f < 3'd4 && sz < 4 && rd[8*sz-1]) rd = rd | (32'hffff_ffff << (8*sz));
            end
        end
    endfunction

    task automatic do_req(input logic wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input int hold, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic exp_er;
        int n;
        ref_op(wr, f, a, wd, exp_rd, exp_er);
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1; bus.req_wr = wr; bus.req_funct3 = f;
        bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0; bus.req_wr = ~wr; bus.req_funct3 = 3'($urandom);
        bus.req_addr = $urandom; bus.req_wdata = $urandom;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.rsp_valid) break;
        end
        chk("latency", 32'(n), 32'(W + 1));
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_er));
        rd = bus.rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("hold_rdata", bus.rsp_rdata, exp_rd);
            chk("hold_err", 32'(bus.rsp_err), 32'(exp_er));
            chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("post_valid", 32'(bus.rsp_valid), 32'd0);
        chk("post_rdata_kept", bus.rsp_rdata, exp_rd);
        chk("post_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd, a;
        logic [2:0] f;
        logic wr;
        bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 1024; i++) mdl[i] = 8'h00;
        bus.req_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_rst", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < 16; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom, 0, rd);
        do_req(1'b1, 3'd2, 32'h10, 32'hdeadbeef, 0, rd);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd);  chk("lw_10", rd, 32'hdeadbeef);
        do_req(1'b0, 3'd0, 32'h13, 32'h0, 0, rd);  chk("lb_13", rd, 32'hffffffde);
        do_req(1'b0, 3'd4, 32'h13, 32'h0, 0, rd);  chk("lbu_13", rd, 32'h000000de);
        do_req(1'b0, 3'd1, 32'h10, 32'h0, 0, rd);  chk("lh_10", rd, 32'hffffbeef);
        do_req(1'b0, 3'd5, 32'h12, 32'h0, 0, rd);  chk("lhu_12", rd, 32'h0000dead);
        do_req(1'b1, 3'd0, 32'h11, 32'h55, 0, rd);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd);  chk("lw_after_sb", rd, 32'hdead55ef);
        do_req(1'b1, 3'd1, 32'h12, 32'h1234, 0, rd);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 0, rd);  chk("lw_after_sh", rd, 32'h123455ef);
        do_req(1'b0, 3'd2, 32'h12, 32'h0, 0, rd);  chk("err_lw_mis", 32'(bus.rsp_err), 32'd1);
        do_req(1'b1, 3'd1, 32'h21, 32'hffff, 0, rd); chk("err_sh_mis", 32'(bus.rsp_err), 32'd1);
        do_req(1'b0, 3'd3, 32'h10, 32'h0, 0, rd);  chk("err_f3", 32'(bus.rsp_err), 32'd1);
        do_req(1'b1, 3'd2, 32'h400, 32'h1, 0, rd); chk("err_oob", 32'(bus.rsp_err), 32'd1);
        do_req(1'b0, 3'd2, 32'h10, 32'h0, 5, rd);  chk("lw_after_errs", rd, 32'h123455ef);
        do_req(1'b1, 3'd2, 32'h20, 32'h11111111, 0, rd);
        bus.req_valid = 1'b1; bus.req_wr = 1'b1; bus.req_funct3 = 3'd2;
        bus.req_addr = 32'h20; bus.req_wdata = 32'haaaaaaaa;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_valid2", 32'(bus.rsp_valid), 32'd0);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, rd);  chk("no_aborted_write", rd, 32'h11111111);
        do_req(1'b1, 3'd2, 32'h20, 32'h0, 0, rd);
        do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, rd);  chk("lw_20_zero", rd, 32'h0);
        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom);
            f = 3'($urandom);
            a = ($urandom_range(0, 9) == 0) ? 32'h400 + 32'($urandom_range(0, 255)) : 32'($urandom_range(0, 63));
            do_req(wr, f, a, $urandom, $urandom_range(0, 2), rd);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
